pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the program counter of the 8-bit CPU and sequences instruction flow.
- Handles sequential advance, `j` and `beq` redirection, and multi-cycle data-memory access for `lwd`/`lwi`/`swd`/`swi`.
- Issues read/write strobes to data memory and stalls on BUSYWAIT.
- Sits between instruction memory (driven by PC), control_unit/ALU (ZERO flag) and data memory.

Parameters:
- PC_WIDTH, 32: width of PC.
- TIMEOUT, 16: maximum cycles in ACCESS before abort. Range 0–255; 0 disables the timeout.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- INSTRUCTION  in  32  current instruction. Opcode is [31:24]; branch offset is [23:16].
- ZERO  in  1  ALU zero flag for the current instruction (beq condition).
- BUSYWAIT  in  1  data memory busy; 1 = access not yet complete.
- PC  out  PC_WIDTH  current instruction address (word address).
- MEM_READ  out  1  registered data-memory read strobe.
- MEM_WRITE  out  1  registered data-memory write strobe.
- STALL  out  1  combinational; 1 = datapath must not commit this cycle.
- WB_EN  out  1  combinational one-cycle pulse; load data valid, register file may write.
- ERR  out  1  sticky timeout error flag.

Behaviour:
- Reset (sampled at a CLK edge with RESET=1):
  - PC=0, MEM_READ=0, MEM_WRITE=0, ERR=0, state=RUN, counter=0.
  - Overrides everything, including mid-ACCESS; strobes drop at that same edge.
- Opcode decode:
  - 0x06 = j, 0x07 = beq.
  - 0x08 = lwd, 0x09 = lwi (load).
  - 0x0A = swd, 0x0B = swi (store).
  - All other opcodes (loadi/mov/add/sub/and/or/undefined) are sequential.
- Target arithmetic:
  - target = PC + 1 + sign_extend(INSTRUCTION[23:16]), modulo 2^PC_WIDTH.
  - Wrap-around is silent. PC+1 from all-ones wraps to 0.
- States: RUN, ACCESS.
- RUN, non-memory opcode:
  - Next edge: PC <= target for j, or for beq with ZERO=1; else PC <= PC+1.
  - STALL=0.
- RUN, memory opcode:
  - STALL=1 combinationally; PC held.
  - Next edge: state <= ACCESS, counter <= 1, MEM_READ <= 1 (load) or MEM_WRITE <= 1 (store).
- ACCESS:
  - PC held. INSTRUCTION is stable because PC is unchanged.
  - BUSYWAIT=1 and (TIMEOUT=0 or counter<TIMEOUT): STALL=1, WB_EN=0; counter increments at edge.
  - BUSYWAIT=0 (completion):
    - STALL=0; WB_EN=1 if MEM_READ=1, else 0.
    - Next edge: strobes <= 0, PC <= PC+1, state <= RUN.
  - BUSYWAIT=1 and TIMEOUT≠0 and counter==TIMEOUT (abort):
    - STALL=0, WB_EN=0.
    - Next edge: strobes <= 0, ERR <= 1, PC <= PC+1, state <= RUN.
- Minimum memory latency: one ACCESS cycle. A strobe is high for at least 1 cycle; the instruction occupies at least 2 cycles.
- MEM_READ and MEM_WRITE are never both 1.
- ERR clears only on RESET.
- ZERO is ignored for every opcode other than beq.

Test Plan:
- Reset and sequential flow:
  - Stimulus: RESET=1 for 2 edges, then three `add` instructions.
  - Required: PC=0, strobes=0, ERR=0 during reset; then PC=1, 2, 3 on successive edges; STALL=0 throughout.
- Jump:
  - Stimulus: at PC=3, `j` with offset 0x02.
  - Required: PC=6.
  - Stimulus: at PC=6, `j` with offset 0xFE.
  - Required: PC=5.
- Branch:
  - Stimulus: at PC=5, `beq` offset 0x04 with ZERO=0.
  - Required: PC=6.
  - Stimulus: repeat from PC=5 with ZERO=1.
  - Required: PC=10.
- Load with wait:
  - Stimulus: at PC=10, `lwd`; BUSYWAIT=1 for the first 3 ACCESS cycles, then 0.
  - Required: MEM_READ high for exactly 4 cycles; STALL high for 4 cycles; WB_EN high only in the 4th ACCESS cycle; PC=10 for 5 cycles, then 11.
- Store timeout (TIMEOUT=8):
  - Stimulus: `swi` with BUSYWAIT stuck at 1.
  - Required: MEM_WRITE high for 8 cycles, then 0; ERR=1 and PC+1 at that edge; WB_EN never 1; ERR stays 1 through later instructions until RESET.
- Reset mid-access:
  - Stimulus: RESET=1 during the 2nd ACCESS cycle of `lwi`.
  - Required: at that edge MEM_READ=0, PC=0, state=RUN; next `add` advances PC to 1.

Source files
------------

// File: rtl/pc_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_seq_if
//  Description : Instruction / data-memory handshake bundle for pc_sequencer.
//  Revision    : 1.0
// ============================================================================
interface pc_seq_if #(
    parameter int PC_WIDTH = 32
) ();
    logic [31:0]         INSTRUCTION;
    logic                ZERO;
    logic                BUSYWAIT;
    logic [PC_WIDTH-1:0] PC;
    logic                MEM_READ;
    logic                MEM_WRITE;
    logic                STALL;
    logic                WB_EN;
    logic                ERR;

    modport master (
        input  INSTRUCTION, ZERO, BUSYWAIT,
        output PC, MEM_READ, MEM_WRITE, STALL, WB_EN, ERR
    );

    modport slave (
        output INSTRUCTION, ZERO, BUSYWAIT,
        input  PC, MEM_READ, MEM_WRITE, STALL, WB_EN, ERR
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter owner; sequential/jump/branch flow and
//                multi-cycle data-memory access with busy-wait timeout.
//  Revision    : 1.0
// ============================================================================
module pc_sequencer #(
    parameter int PC_WIDTH = 32,
    parameter int TIMEOUT  = 16
) (
    input  wire logic CLK,
    input  wire logic RESET,
    pc_seq_if.master  bus
);
    localparam logic       c_st_run    = 1'b0;
    localparam logic       c_st_access = 1'b1;
    localparam logic [7:0] c_timeout   = 8'(TIMEOUT);
    localparam logic [PC_WIDTH-1:0] c_pc_one = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    localparam logic [7:0] c_op_j    = 8'h06;
    localparam logic [7:0] c_op_beq  = 8'h07;
    localparam logic [7:0] c_op_lwd  = 8'h08;
    localparam logic [7:0] c_op_lwi  = 8'h09;
    localparam logic [7:0] c_op_swd  = 8'h0A;
    localparam logic [7:0] c_op_swi  = 8'h0B;

    logic                state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;

    logic                w_stall;
    logic                w_wb_en;

    // Decode
    logic [7:0]          w_opcode;
    logic [7:0]          w_offset;
    logic                w_is_j, w_is_beq, w_is_load, w_is_store, w_is_mem;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_target;
    logic                w_timeout_hit;
    logic                w_unused_ok;

    assign w_opcode    = bus.INSTRUCTION[31:24];
    assign w_offset    = bus.INSTRUCTION[23:16];
    assign w_unused_ok = &{1'b0, bus.INSTRUCTION[15:0]};

    assign w_is_j      = (w_opcode == c_op_j);
    assign w_is_beq    = (w_opcode == c_op_beq);
    assign w_is_load   = (w_opcode == c_op_lwd) || (w_opcode == c_op_lwi);
    assign w_is_store  = (w_opcode == c_op_swd) || (w_opcode == c_op_swi);
    assign w_is_mem    = w_is_load || w_is_store;

    assign w_pc_inc    = pc_q + c_pc_one;
    assign w_target    = w_pc_inc + {{(PC_WIDTH-8){w_offset[7]}}, w_offset};

    // A zero TIMEOUT means the access waits on BUSYWAIT indefinitely.
    assign w_timeout_hit = (c_timeout != 8'd0) && (cnt_q == c_timeout);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= c_st_run;
            pc_q    <= '0;
            cnt_q   <= 8'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        case (state_q)
            c_st_run: begin
                if (w_is_mem) begin
                    state_d = c_st_access;
                    cnt_d   = 8'd1;
                    rd_d    = w_is_load;
                    wr_d    = w_is_store;
                end else if (w_is_j || (w_is_beq && bus.ZERO)) begin
                    pc_d = w_target;
                end else begin
                    pc_d = w_pc_inc;
                end
            end
            c_st_access: begin
                if (!bus.BUSYWAIT || w_timeout_hit) begin
                    state_d = c_st_run;
                    pc_d    = w_pc_inc;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    cnt_d   = 8'd0;
                    if (bus.BUSYWAIT) begin
                        err_d = 1'b1;
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = c_st_run;
            end
        endcase
    end

    // Output logic
    always_comb begin
        w_stall = 1'b0;
        w_wb_en = 1'b0;
        case (state_q)
            c_st_run: begin
                w_stall = w_is_mem;
            end
            c_st_access: begin
                w_stall = bus.BUSYWAIT && !w_timeout_hit;
                w_wb_en = !bus.BUSYWAIT && rd_q;
            end
            default: begin
                w_stall = 1'b0;
                w_wb_en = 1'b0;
            end
        endcase
    end

    assign bus.PC        = pc_q;
    assign bus.MEM_READ  = rd_q;
    assign bus.MEM_WRITE = wr_q;
    assign bus.STALL     = w_stall;
    assign bus.WB_EN     = w_wb_en;
    assign bus.ERR       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer against an
//                instruction-level reference model.
//  Revision    : 1.0
// ============================================================================
module tb_pc_sequencer;
    localparam int c_pc_width = 32;
    localparam int c_timeout  = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    logic [31:0] m_pc;
    logic        m_err;

    pc_seq_if #(.PC_WIDTH(c_pc_width)) bus ();

    pc_sequencer #(
        .PC_WIDTH (c_pc_width),
        .TIMEOUT  (c_timeout)
    ) u_dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string tag, input logic stall, input logic wb,
                             input logic rd, input logic wr);
        chk({tag, ".pc"},    bus.PC,        m_pc);
        chk({tag, ".stall"}, 32'(bus.STALL),     32'(stall));
        chk({tag, ".wb_en"}, 32'(bus.WB_EN),     32'(wb));
        chk({tag, ".rd"},    32'(bus.MEM_READ),  32'(rd));
        chk({tag, ".wr"},    32'(bus.MEM_WRITE), 32'(wr));
        chk({tag, ".err"},   32'(bus.ERR),       32'(m_err));
    endtask

    // One whole instruction: the model predicts every cycle it occupies.
    // busy = number of ACCESS cycles in which BUSYWAIT is held high.
    task automatic run_instr(input string tag, input logic [7:0] op, input logic [7:0] off,
                             input logic zero, input int busy);
        logic is_load, is_store, aborted;
        int   n_acc;
        logic [31:0] target;
        is_load  = (op == 8'h08) || (op == 8'h09);
        is_store = (op == 8'h0A) || (op == 8'h0B);
        target   = m_pc + 32'd1 + {{24{off[7]}}, off};
        bus.INSTRUCTION = {op, off, 16'($urandom)};
        bus.ZERO        = zero;
        bus.BUSYWAIT    = 1'($urandom);
        @(negedge clk);
        if (is_load || is_store) begin
            chk_cycle({tag, ".issue"}, 1'b1, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            aborted = (c_timeout != 0) && (busy >= c_timeout);
            n_acc   = aborted ? c_timeout : busy + 1;
            for (int k = 1; k <= n_acc; k++) begin
                bus.BUSYWAIT = (k <= busy);
                @(negedge clk);
                chk_cycle({tag, ".acc"}, (k <= busy) && !(aborted && k == n_acc),
                          is_load && (k > busy), is_load, is_store);
                @(posedge clk); #1;
            end
            m_pc = m_pc + 32'd1;
            if (aborted) m_err = 1'b1;
        end else begin
            chk_cycle({tag, ".seq"}, 1'b0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            if (op == 8'h06 || (op == 8'h07 && zero)) m_pc = target;
            else m_pc = m_pc + 32'd1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.INSTRUCTION = {8'h02, 24'($urandom)};
        repeat (2) begin
            @(posedge clk); #1;
            chk("reset.pc",  bus.PC, 32'd0);
            chk("reset.rd",  32'(bus.MEM_READ),  32'd0);
            chk("reset.wr",  32'(bus.MEM_WRITE), 32'd0);
            chk("reset.err", 32'(bus.ERR),       32'd0);
        end
        rst   = 1'b0;
        m_pc  = 32'd0;
        m_err = 1'b0;
    endtask

    initial begin
        logic [7:0] op;
        n_tests = 0;
        n_fail  = 0;
        m_pc    = 32'd0;
        m_err   = 1'b0;
        rst     = 1'b1;
        bus.INSTRUCTION = 32'h0;
        bus.ZERO        = 1'b0;
        bus.BUSYWAIT    = 1'b0;
        @(posedge clk); #1;

        do_reset();
        run_instr("add0", 8'h02, 8'h00, 1'b1, 0);
        run_instr("add1", 8'h02, 8'h11, 1'b0, 0);
        run_instr("add2", 8'h02, 8'h22, 1'b1, 0);
        chk("seq.pc3", bus.PC, 32'd3);
        run_instr("j_fwd", 8'h06, 8'h02, 1'b0, 0);
        chk("j_fwd.pc6", bus.PC, 32'd6);
        run_instr("j_back", 8'h06, 8'hFE, 1'b0, 0);
        chk("j_back.pc5", bus.PC, 32'd5);
        run_instr("beq_nt", 8'h07, 8'h04, 1'b0, 0);
        chk("beq_nt.pc6", bus.PC, 32'd6);
        run_instr("j_back2", 8'h06, 8'hFE, 1'b1, 0);
        run_instr("beq_t", 8'h07, 8'h04, 1'b1, 0);
        chk("beq_t.pc10", bus.PC, 32'd10);
        run_instr("lwd", 8'h08, 8'h00, 1'b0, 3);
        chk("lwd.pc11", bus.PC, 32'd11);
        run_instr("swi_to", 8'h0B, 8'h00, 1'b0, 40);
        chk("swi_to.err", 32'(bus.ERR), 32'd1);
        run_instr("add_err", 8'h03, 8'h00, 1'b0, 0);
        run_instr("lwi_ok", 8'h09, 8'h00, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            op = ($urandom % 16 < 12) ? 8'($urandom % 12) : 8'($urandom);
            run_instr("rand", op, 8'($urandom), 1'($urandom), int'($urandom % 12));
        end

        // PC wrap-around in both directions
        do_reset();
        run_instr("wrap_j", 8'h06, 8'hFE, 1'b0, 0);
        chk("wrap_j.pc", bus.PC, 32'hFFFF_FFFF);
        run_instr("wrap_add", 8'h04, 8'h00, 1'b0, 0);
        chk("wrap_add.pc", bus.PC, 32'd0);

        // Reset during the second ACCESS cycle of lwi
        run_instr("pre", 8'h02, 8'h00, 1'b0, 0);
        bus.INSTRUCTION = {8'h09, 24'h0};
        bus.BUSYWAIT    = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid.acc1.rd", 32'(bus.MEM_READ), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_pc  = 32'd0;
        m_err = 1'b0;
        chk("mid.rd", 32'(bus.MEM_READ), 32'd0);
        chk("mid.pc", bus.PC, 32'd0);
        run_instr("mid_add", 8'h02, 8'h00, 1'b0, 0);
        chk("mid_add.pc1", bus.PC, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
